// File: rtl/arb_pkg.sv
// Shared arbitration types for the rr_arbiter_n family.
package arb_pkg;
  localparam logic ARB_MODE_RR    = 1'b0;
  localparam logic ARB_MODE_FIXED = 1'b1;

  typedef enum logic {ARB_IDLE, ARB_GRANTED} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational winner select: round-robin after start_i, or lowest index in fixed mode.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     cand_i,
  input  logic [IDX_W-1:0] start_i,
  input  logic             mode_i,
  output logic [N-1:0]     win_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);
  always_comb begin
    int   j;
    logic found;
    j     = 0;
    found = 1'b0;
    win_o = '0;
    idx_o = '0;
    any_o = |cand_i;
    // Search order: start+1, start+2, ... wrapping, so the last winner is tried last.
    for (int k = 0; k < N; k++) begin
      if (mode_i == ARB_MODE_FIXED) begin
        j = k;
      end else begin
        j = int'(start_i) + 1 + k;
        if (j >= N) j = j - N;
      end
      if (!found && cand_i[j]) begin
        found    = 1'b1;
        win_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/rr_arbiter_n.sv
// N-requester arbiter with registered one-hot grant, lock and hold-limit forced release.
module rr_arbiter_n
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDX_W    = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     lock,
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

  arb_state_t       state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic             granted, others, keep, forced;
  logic [N-1:0]     cand, win;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;

  assign granted = (state_q == ARB_GRANTED);
  assign others  = |(req & ~grant_q);
  assign keep    = granted && req[idx_q] && lock[idx_q] &&
                   ((hold_q < HOLD_LIM) || !others);
  assign forced  = granted && lock[idx_q] && (hold_q == HOLD_LIM) && others;
  // The expiring owner sits out one arbitration so someone else gets served.
  assign cand    = forced ? (req & ~grant_q) : req;

  rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .cand_i  (cand),
    .start_i (last_q),
    .mode_i  (mode),
    .win_o   (win),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    last_d  = last_q;
    hold_d  = hold_q;
    if (keep) begin
      if (hold_q < HOLD_LIM) hold_d = hold_q + 1'b1;
    end else if (win_any) begin
      state_d = ARB_GRANTED;
      grant_d = win;
      idx_d   = win_idx;
      last_d  = win_idx;
      hold_d  = '0;
    end else begin
      state_d = ARB_IDLE;
      grant_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      last_q  <= IDX_W'(N - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = granted;
  assign grant_idx   = idx_q;
endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n (N=4, MAX_HOLD=3).
module tb_rr_arbiter_n;
  localparam int N = 4;
  localparam int MAX_HOLD = 3;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             mode = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     lock = '0;
  logic [N-1:0]     grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;

  int checks = 0;
  int errors = 0;

  rr_arbiter_n #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .req         (req),
    .lock        (lock),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset: grant=%b valid=%b idx=%0d, need 0000/0/0", grant, grant_valid, grant_idx);
    end
    tick();
    reset = 1'b0;
  endtask

  // First grant one cycle after req; then 0,1,2,3,0,1,2,3 with no bubble.
  task automatic test_rr_rotation();
    mode = 1'b0; lock = '0; req = 4'b1111;
    #1;
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_latency: valid=%b before edge, need 0", grant_valid);
    end
    for (int i = 0; i < 8; i++) begin
      logic [N-1:0] eg;
      eg = 4'b0001 << (i % 4);
      tick();
      checks++;
      if (grant !== eg || grant_idx !== IDX_W'(i % 4) || grant_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_rotation cyc %0d: grant=%b idx=%0d, need %b/%0d", i, grant, grant_idx, eg, i % 4);
      end
    end
  endtask

  // Continues from a grant on index 3.
  task automatic test_wrap_idle();
    req = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (grant_valid !== 1'b0 || grant !== 4'b0000 || grant_idx !== 2'd3) begin
        errors++;
        $display("FAIL idle cyc %0d: grant=%b valid=%b idx=%0d, need 0000/0/3", i, grant, grant_valid, grant_idx);
      end
    end
    req = 4'b1001;
    tick();
    checks++;
    if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL wrap: grant=%b idx=%0d, need 0001/0", grant, grant_idx);
    end
    tick();
    checks++;
    if (grant !== 4'b1000 || grant_idx !== 2'd3) begin
      errors++;
      $display("FAIL wrap_next: grant=%b idx=%0d, need 1000/3", grant, grant_idx);
    end
  endtask

  task automatic test_fixed();
    mode = 1'b1; req = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0010 || grant_idx !== 2'd1) begin
        errors++;
        $display("FAIL fixed cyc %0d: grant=%b idx=%0d, need 0010/1", i, grant, grant_idx);
      end
    end
    req = 4'b1000;
    tick();
    checks++;
    if (grant !== 4'b1000 || grant_idx !== 2'd3) begin
      errors++;
      $display("FAIL fixed_drop: grant=%b idx=%0d, need 1000/3", grant, grant_idx);
    end
  endtask

  // Owner 0 locked: three cycles, forced release to 1, then back to 0.
  task automatic test_lock_hold(input logic m);
    logic [IDX_W-1:0] exp_seq [12];
    exp_seq = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
    mode = m; req = 4'b0011; lock = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (grant_idx !== exp_seq[i] || grant !== (4'b0001 << exp_seq[i])) begin
        errors++;
        $display("FAIL lock_hold mode %0d cyc %0d: grant=%b idx=%0d, need idx %0d", m, i, grant, grant_idx, exp_seq[i]);
      end
    end
    req = 4'b1000; lock = '0;
    tick();
  endtask

  task automatic test_sole_lock();
    mode = 1'b0; req = 4'b0100; lock = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0100 || grant_idx !== 2'd2) begin
        errors++;
        $display("FAIL sole_lock cyc %0d: grant=%b idx=%0d, need 0100/2", i, grant, grant_idx);
      end
    end
    // Dropping req releases even with lock held.
    req = 4'b0001;
    tick();
    checks++;
    if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL drop_release: grant=%b idx=%0d, need 0001/0", grant, grant_idx);
    end
  endtask

  task automatic test_async_reset();
    mode = 1'b0; req = 4'b0100; lock = 4'b0100;
    tick(); tick();
    checks++;
    if (grant !== 4'b0100) begin
      errors++;
      $display("FAIL pre_reset: grant=%b, need 0100", grant);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: grant=%b valid=%b idx=%0d, need 0000/0/0", grant, grant_valid, grant_idx);
    end
    req = 4'b1111; lock = '0;
    tick();
    #2 reset = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL post_reset: grant=%b idx=%0d, need 0001/0", grant, grant_idx);
    end
  endtask

  initial begin
    test_reset();
    test_rr_rotation();
    test_wrap_idle();
    test_fixed();
    test_lock_hold(1'b0);
    test_lock_hold(1'b1);
    test_sole_lock();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_n.md
# rr_arbiter_n

Parametrised N-requester arbiter with registered one-hot grants. It generalises the two-port alternating arbiter to N ports and adds three features: a selectable round-robin or fixed-priority mode, grant locking for multi-cycle transfers, and a hold limit that forces release so no requester starves. It sits in front of any shared resource in the pipeline, such as a memory port, writeback bus or shared functional unit, that several stages contend for.

## Interface
Parameters:
- N, 4, number of requesters; legal range N ≥ 2.
- MAX_HOLD, 8, maximum consecutive cycles one grant may be held under lock while other requests are pending; legal range MAX_HOLD ≥ 1.
- IDX_W, $clog2(N), width of grant_idx; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high.
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- req  input  N  per-requester request, level-sensitive.
- lock  input  N  per-requester hold; lock[i] is meaningful only while grant[i]=1.
- grant  output  N  registered one-hot grant, or all zero.
- grant_valid  output  1  OR of grant, registered.
- grant_idx  output  IDX_W  index of the set grant bit; holds its last value when grant_valid=0.

## Operation
- States: IDLE (no grant) and GRANTED (exactly one grant bit set).
- Internal registers:
  - last: index of the most recent newly issued grant; resets to N-1.
  - hold_cnt: width $clog2(MAX_HOLD+1); counts cycles the current owner g has held past its first cycle.
- Each cycle, next state is decided from current req, lock, mode and state:
  - Keep: in GRANTED with owner g, req[g]=1, lock[g]=1, and either hold_cnt < MAX_HOLD-1 or no other req bit set. Result: grant unchanged; hold_cnt increments, saturating at MAX_HOLD-1.
  - Forced release: in GRANTED, lock[g]=1, hold_cnt = MAX_HOLD-1, and another req pending. Result: arbitrate with req[g] masked out.
  - Arbitrate: any other case with req ≠ 0. Result: pick the winner w, grant[w]=1, last←w, hold_cnt←0.
  - Idle: req = 0. Result: grant←0, state←IDLE; last and grant_idx unchanged.
- Winner selection:
  - Round-robin (mode=0): first set candidate bit searching last+1, last+2, … with wrap-around modulo N.
  - Fixed priority (mode=1): lowest set candidate index.
- A requester with lock deasserted that is re-arbitrated may win again. This happens only if it is the sole candidate (round-robin) or the highest-priority candidate (fixed).
- A mode change takes effect at the next Arbitrate decision; it never breaks an active lock.
- lock bits for non-owners are ignored.
- A req bit dropping while its holder is granted always releases the grant, regardless of lock.

## Timing
- Grant latency: 1 cycle; grant reflects req sampled at the previous rising edge. There is no combinational path from req to grant.
- Back-to-back handover: a new owner can be granted in the cycle immediately after release, with no idle bubble.
- Reset: on assertion, immediately grant=0, grant_valid=0, grant_idx=0, last=N-1, hold_cnt=0, state=IDLE.
- Reset mid-operation: the lock is abandoned. The first post-reset arbitration in round-robin mode favours index 0.
- Locked throughput: maximum continuous ownership under contention is MAX_HOLD cycles, after which at least one other requester is served before the owner can regain the grant.

## Structure
- Shared package arb_pkg holds:
  - Mode constants ARB_MODE_RR=1'b0 and ARB_MODE_FIXED=1'b1.
  - State enum arb_state_t {ARB_IDLE, ARB_GRANTED}.
- Sub-module rr_pick (combinational):
  - Inputs: N-bit candidate mask, start index, mode.
  - Outputs: one-hot winner, winner index, any-valid.
  - Reused by future multi-port arbiters.
- The top level holds the state, last, hold_cnt and the output registers.

## Test plan
- Round-robin rotation: N=4, mode=0, req=4'b1111 constant, lock=0 from reset. Required: grant_idx sequence 0,1,2,3,0,… one per cycle, with first grant one cycle after req.
- Fixed priority: mode=1, req=4'b1010. Required: grant_idx=1 every cycle. Dropping req[1] gives grant_idx=3 on the next cycle.
- Lock with hold limit: MAX_HOLD=3, req=4'b0011, lock[0]=1 held. Required: grant_idx 0,0,0 then 1, then 0 again for 3 cycles, repeating.
- Sole locked requester: req=4'b0100, lock[2]=1 for 20 cycles. Required: grant[2] held continuously; hold_cnt saturates and no release occurs.
- Wrap and idle: grant on index 3, then req=0 for 2 cycles, then req=4'b1001. Required:
  - grant_valid=0 during idle, with grant_idx still 3.
  - Next grant goes to index 0 (wrap-around from last=3).
- Async reset mid-lock: assert reset between clock edges while grant[2] is locked. Required: outputs zero immediately. After release with req=4'b1111, the first grant is index 0.
